// File: rtl/sram_pkg.sv
// Shared types and default sizes for the single-port SRAM block.
package sram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } sram_state_t;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;

endpackage

// File: rtl/sram_parity_gen.sv
// Even-parity generator: XOR reduction of one data word.
module sram_parity_gen #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ^data;

endmodule

// File: rtl/sram_sp.sv
// Single-port SRAM with power-up clear sequencer and registered read port.
// Optional per-word even parity is enabled by defining SRAM_PARITY_EN.
module sram_sp
  import sram_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err,
  output logic              parity_err
);

  // Handshake: a request is accepted when en=1 and busy=0 (busy is an inverted
  // ready); an accepted read answers with rd_valid exactly one cycle later.
  sram_state_t       state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              in_range, accept, wr_ok, rd_ok;
  logic [DATA_W-1:0] rd_word;

  assign busy     = (state_q == ST_INIT);
  assign in_range = (32'(address) < DEPTH);
  assign accept   = en && (state_q == ST_IDLE);
  assign wr_ok    = accept && read_write && in_range;
  assign rd_ok    = accept && !read_write;
  assign rd_word  = in_range ? mem[address] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (32'(init_cnt_q) == DEPTH - 1) begin
          state_d    = ST_IDLE;
          init_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Storage has no reset; the init sequencer is the only way it gets cleared.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_ok) begin
      mem[address] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      addr_err <= accept && !in_range;
      if (rd_ok) begin
        data_out <= rd_word;
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic par_mem [DEPTH];
  logic wr_par, rd_par;

  sram_parity_gen #(.DATA_W(DATA_W)) u_par_wr (.data(data_in), .parity(wr_par));
  sram_parity_gen #(.DATA_W(DATA_W)) u_par_rd (.data(rd_word), .parity(rd_par));

  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      par_mem[init_cnt_q] <= 1'b0;
    end else if (wr_ok) begin
      par_mem[address] <= wr_par;
    end
  end

  // Out-of-range reads return zero data and never flag parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= rd_ok && in_range && (rd_par != par_mem[address]);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_sp.sv
// Self-checking bench for sram_sp: DEPTH=16 and DEPTH=12 instances against an array model.
module tb_sram_sp;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic       en = 1'b0, read_write = 1'b0;
  logic [3:0] address = '0;
  logic [7:0] data_in = '0, data_out;
  logic       rd_valid, busy, addr_err, parity_err;

  // DEPTH=12 instance (non power of two, exercises out-of-range addresses)
  logic       en12 = 1'b0, rw12 = 1'b0;
  logic [3:0] addr12 = '0;
  logic [7:0] din12 = '0, data_out12;
  logic       rd_valid12, busy12, addr_err12, parity_err12;

  sram_sp #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .read_write(read_write), .address(address),
    .data_in(data_in), .data_out(data_out), .rd_valid(rd_valid), .busy(busy),
    .addr_err(addr_err), .parity_err(parity_err)
  );

  sram_sp #(.DATA_W(8), .DEPTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .en(en12), .read_write(rw12), .address(addr12),
    .data_in(din12), .data_out(data_out12), .rd_valid(rd_valid12), .busy(busy12),
    .addr_err(addr_err12), .parity_err(parity_err12)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model16 [16];
  logic       corrupt16 [16];
  logic [7:0] model12 [12];
  logic [7:0] last16, last12;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_busy", busy, 1);
    check("rst_data_out12", data_out12, 0);
    check("rst_busy12", busy12, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      model16[i] = '0;
      corrupt16[i] = 1'b0;
    end
    for (int i = 0; i < 12; i++) model12[i] = '0;
    last16 = '0;
    last12 = '0;
  endtask

  // Counts busy cycles while hammering both instances with requests that must be ignored.
  task automatic wait_init();
    int n = 0;
    en = 1'b1; read_write = 1'b1; address = 4'd7; data_in = 8'hFF;
    en12 = 1'b1; rw12 = 1'b1; addr12 = 4'd13; din12 = 8'hEE;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
      check("init_rd_valid", rd_valid, 0);
      check("init_addr_err", addr_err, 0);
      check("init_addr_err12", addr_err12, 0);
      check("init_busy12", busy12, (n < 12));
      if (n == 12) en12 = 1'b0;
    end
    check("busy_cycles", n, 16);
    en = 1'b0;
    en12 = 1'b0;
  endtask

  task automatic op16(input logic e, input logic rw, input logic [3:0] a, input logic [7:0] d);
    logic rd;
    en = e; read_write = rw; address = a; data_in = d;
    @(posedge clk); #1;
    rd = e && !rw;
    if (rd) exp_q.push_back(model16[a]);
    check("rd_valid16", rd_valid, rd);
    check("addr_err16", addr_err, 0);
    check("parity_err16", parity_err, rd && corrupt16[a]);
    if (rd) last16 = exp_q.pop_front();
    check("data_out16", data_out, last16);
    if (e && rw) begin
      model16[a] = d;
      corrupt16[a] = 1'b0;
    end
    en = 1'b0;
  endtask

  task automatic op12(input logic e, input logic rw, input logic [3:0] a, input logic [7:0] d);
    logic rd, inr;
    en12 = e; rw12 = rw; addr12 = a; din12 = d;
    @(posedge clk); #1;
    rd  = e && !rw;
    inr = (a < 4'd12);
    if (rd) exp_q.push_back(inr ? model12[a] : 8'h00);
    check("rd_valid12", rd_valid12, rd);
    check("addr_err12", addr_err12, e && !inr);
    check("parity_err12", parity_err12, 0);
    if (rd) last12 = exp_q.pop_front();
    check("data_out12", data_out12, last12);
    if (e && rw && inr) model12[a] = d;
    en12 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    apply_reset();
    wait_init();

    // Everything reads back zero after the clear, including words targeted during init.
    for (int i = 0; i < 16; i++) op16(1'b1, 1'b0, 4'(i), 8'h00);
    for (int i = 0; i < 12; i++) op12(1'b1, 1'b0, 4'(i), 8'h00);

    // Read-after-write, then an idle cycle where rd_valid drops and data_out holds.
    op16(1'b1, 1'b1, 4'd3, 8'hA5);
    op16(1'b1, 1'b0, 4'd3, 8'h00);
    op16(1'b0, 1'b0, 4'd0, 8'h00);
    op16(1'b0, 1'b1, 4'd3, 8'h11);
    op16(1'b1, 1'b0, 4'd3, 8'h00);

    // Out-of-range access on the DEPTH=12 instance.
    for (int i = 0; i < 12; i++) op12(1'b1, 1'b1, 4'(i), 8'(8'h40 + i));
    op12(1'b1, 1'b0, 4'd5, 8'h00);
    op12(1'b1, 1'b0, 4'd13, 8'h00);
    op12(1'b1, 1'b1, 4'd13, 8'h77);
    op12(1'b1, 1'b1, 4'd12, 8'h78);
    for (int i = 0; i < 12; i++) op12(1'b1, 1'b0, 4'(i), 8'h00);

    // Randomized traffic against the array model.
    repeat (300) op16($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    repeat (300) op12($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));

`ifdef SRAM_PARITY_EN
    op16(1'b1, 1'b1, 4'd2, 8'h01);
    op16(1'b1, 1'b0, 4'd2, 8'h00);
    dut.mem[2] = dut.mem[2] ^ 8'h01;
    model16[2] = model16[2] ^ 8'h01;
    corrupt16[2] = 1'b1;
    op16(1'b1, 1'b0, 4'd2, 8'h00);
    op16(1'b1, 1'b1, 4'd4, 8'h07);
    op16(1'b1, 1'b0, 4'd4, 8'h00);
`endif

    // Reset while idle aborts state and restarts the full clear.
    op16(1'b1, 1'b1, 4'd5, 8'h3C);
    op16(1'b1, 1'b0, 4'd5, 8'h00);
    apply_reset();
    wait_init();
    op16(1'b1, 1'b0, 4'd5, 8'h00);
    op16(1'b1, 1'b0, 4'd3, 8'h00);

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_sp.md
SRAM_SP -- requirements
Module: sram_sp

Interface
REQ-001 SHALL have parameter: DATA_W, 8, word width in bits.
REQ-002 SHALL have parameter: DEPTH, 16, number of words, 2 or more, any integer.
REQ-003 SHALL have derived parameter: ADDR_W, $clog2(DEPTH), address width.
REQ-004 SHALL have port: clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: en  input  1  access request for this cycle.
REQ-007 SHALL have port: read_write  input  1  operation select, 1 = write, 0 = read.
REQ-008 SHALL have port: address  input  ADDR_W  word address.
REQ-009 SHALL have port: data_in  input  DATA_W  write data.
REQ-010 SHALL have port: data_out  output  DATA_W  registered read data.
REQ-011 SHALL have port: rd_valid  output  1  one-cycle pulse, data_out updated.
REQ-012 SHALL have port: busy  output  1  init clear in progress; requests ignored.
REQ-013 SHALL have port: addr_err  output  1  one-cycle pulse, accepted request had address >= DEPTH.
REQ-014 SHALL have port: parity_err  output  1  read parity mismatch; see Configuration.

Function
REQ-015 SHALL use a two-state FSM: ST_INIT and ST_IDLE.
REQ-016 ST_INIT SHALL write 0 to one word per cycle, addresses 0..DEPTH-1, and take exactly DEPTH cycles; it SHALL then go to ST_IDLE.
REQ-017 busy SHALL equal 1 in ST_INIT and 0 in ST_IDLE.
REQ-018 While busy=1, en SHALL be ignored; there SHALL be no writes, no rd_valid and no addr_err.
REQ-019 In ST_IDLE, en=1 and read_write=1 SHALL write data_in to mem[address] at the rising edge.
REQ-020 In ST_IDLE, en=1 and read_write=0 SHALL load data_out with mem[address] at the rising edge and assert rd_valid for exactly that following cycle; read latency is 1 cycle.
REQ-021 Read-after-write to the same address on the next cycle SHALL return the newly written data.
REQ-022 data_out SHALL hold its last value when no read is accepted.
REQ-023 en=0 SHALL leave memory and data_out unchanged.
REQ-024 An accepted request with address >= DEPTH (possible only when DEPTH is not a power of 2) SHALL:
  - pulse addr_err for one cycle;
  - not write;
  - on a read, load data_out with 0 and still pulse rd_valid.
REQ-025 Only one operation SHALL occur per cycle (single port); read_write is sampled only when en=1.

Reset
REQ-026 rst_n=0 SHALL asynchronously force:
  - data_out=0, rd_valid=0, addr_err=0, parity_err=0;
  - busy=1, FSM=ST_INIT, init counter=0.
REQ-027 Reset asserted mid-operation (in ST_INIT or ST_IDLE) SHALL abort that operation; after release the full DEPTH-cycle clear SHALL restart from address 0.
REQ-028 Memory contents SHALL not be reset asynchronously; they SHALL be cleared only by ST_INIT.

Configuration
REQ-029 With macro SRAM_PARITY_EN defined:
  - each word SHALL store one extra even-parity bit computed from data_in on write (0 during init);
  - each read SHALL recompute parity; parity_err SHALL pulse together with rd_valid on mismatch;
  - an out-of-range read SHALL give parity_err=0.
REQ-030 Without SRAM_PARITY_EN, no parity storage SHALL exist and parity_err SHALL be tied to 0.

Structure
REQ-031 Shared package sram_pkg SHALL hold:
  - the state enum (ST_INIT, ST_IDLE);
  - defaults DATA_W_DEF=8 and DEPTH_DEF=16.
REQ-032 Sub-module sram_parity_gen (DATA_W-bit XOR reduction) SHALL be instantiated for write and read paths only under SRAM_PARITY_EN.

Verification
REQ-033 Reset then release, DATA_W=8, DEPTH=16 -> busy=1 for exactly 16 cycles; afterwards, reading every address returns 0x00 with rd_valid pulses.
REQ-034 Write 0xA5 to address 3, then read address 3 on the next cycle -> data_out=0xA5 one cycle after the read, rd_valid high for 1 cycle.
REQ-035 Issue en=1 writes while busy=1 -> after init, read of that address returns 0x00, and addr_err never pulses during init.
REQ-036 DEPTH=12: read address 13 -> addr_err=1 and rd_valid=1 for 1 cycle, data_out=0x00; write to address 13 leaves addresses 0..11 unchanged.
REQ-037 Write 0x3C to address 5, assert rst_n=0 mid-idle, release -> outputs 0 during reset, busy restarts for 16 cycles, then read of address 5 returns 0x00.
REQ-038 SRAM_PARITY_EN defined: write 0x01 to address 2, bench flips the stored data bit hierarchically, then reads address 2 -> parity_err=1 coincident with rd_valid; a clean word gives parity_err=0.
